// File: rtl/dkong_video_pkg.sv
// Shared definitions for the dkong video slice: object-RAM geometry and the
// object DMA controller's state encoding.
package dkong_video_pkg;

    localparam int unsigned OBJ_RAM_AW = 10;
    localparam logic [9:0]  DKONG_OBJ_DMA_LEN = 10'h180;

    typedef enum logic [2:0] {
        DMA_IDLE,
        DMA_REQ,
        DMA_READ,
        DMA_LATCH,
        DMA_WRITE,
        DMA_RELEASE
    } dkong_obj_dma_state_e;

endpackage

// File: rtl/dkong_obj_dma.sv
// Copies the CPU's sprite shadow table into object RAM once per vblank,
// holding the Z80 off the bus for the duration of the copy.
module dkong_obj_dma
    import dkong_video_pkg::*;
#(
    parameter logic [15:0] SRC_BASE = 16'h6900,
    parameter int unsigned XFER_LEN = DKONG_OBJ_DMA_LEN
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  dma_en,
    input  logic                  vblk,
    output logic                  busrq_n,
    input  logic                  busak_n,
    output logic [15:0]           src_addr,
    output logic                  src_rd,
    input  logic [7:0]            src_data,
    output logic [OBJ_RAM_AW-1:0] obj_addr,
    output logic [7:0]            obj_data,
    output logic                  obj_wrn,
    output logic                  obj_ena,
    input  logic                  vram_busy,
    output logic                  dma_busy,
    output logic                  overrun
);

    localparam logic [OBJ_RAM_AW-1:0] LAST_IDX = OBJ_RAM_AW'(XFER_LEN - 1);

    dkong_obj_dma_state_e  state_q;
    logic                  vblk_q;
    logic [OBJ_RAM_AW-1:0] idx_q;
    logic [OBJ_RAM_AW-1:0] idx_d;
    logic                  busrq_n_q;
    logic                  src_rd_q;
    logic [15:0]           src_addr_q;
    logic [7:0]            obj_data_q;
    logic                  dma_busy_q;
    logic                  overrun_q;

    logic trigger;
    logic wr_fire;

    assign trigger = vblk && !vblk_q && dma_en;
    assign idx_d   = idx_q + 1'b1;

    // The strobe is gated by vram_busy in the same clk so a byte lands the
    // instant the video block lets go, keeping the 3 clk/byte cadence.
    assign wr_fire = (state_q == DMA_WRITE) && !vram_busy;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q    <= DMA_IDLE;
            vblk_q     <= 1'b0;
            idx_q      <= '0;
            busrq_n_q  <= 1'b1;
            src_rd_q   <= 1'b0;
            src_addr_q <= '0;
            obj_data_q <= '0;
            dma_busy_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            vblk_q    <= vblk;
            overrun_q <= trigger && (state_q != DMA_IDLE);
            src_rd_q  <= 1'b0;
            case (state_q)
                DMA_IDLE: begin
                    if (trigger) begin
                        idx_q      <= '0;
                        busrq_n_q  <= 1'b0;
                        dma_busy_q <= 1'b1;
                        state_q    <= DMA_REQ;
                    end
                end
                DMA_REQ: begin
                    if (!busak_n) begin
                        src_addr_q <= SRC_BASE + {6'd0, idx_q};
                        src_rd_q   <= 1'b1;
                        state_q    <= DMA_READ;
                    end
                end
                DMA_READ: begin
                    state_q <= DMA_LATCH;
                end
                DMA_LATCH: begin
                    obj_data_q <= src_data;
                    state_q    <= DMA_WRITE;
                end
                DMA_WRITE: begin
                    if (wr_fire) begin
                        if (idx_q == LAST_IDX) begin
                            busrq_n_q <= 1'b1;
                            state_q   <= DMA_RELEASE;
                        end else begin
                            idx_q      <= idx_d;
                            src_addr_q <= SRC_BASE + {6'd0, idx_d};
                            src_rd_q   <= 1'b1;
                            state_q    <= DMA_READ;
                        end
                    end
                end
                DMA_RELEASE: begin
                    if (busak_n) begin
                        dma_busy_q <= 1'b0;
                        state_q    <= DMA_IDLE;
                    end
                end
                default: begin
                    state_q <= DMA_IDLE;
                end
            endcase
        end
    end

    assign busrq_n  = busrq_n_q;
    assign src_rd   = src_rd_q;
    assign src_addr = src_addr_q;
    assign obj_addr = idx_q;
    assign obj_data = obj_data_q;
    assign obj_wrn  = !wr_fire;
    assign obj_ena  = wr_fire;
    assign dma_busy = dma_busy_q;
    assign overrun  = overrun_q;

endmodule

// File: doc/dkong_obj_dma.md
DKONG_OBJ_DMA -- requirements
Module: dkong_obj_dma

Interface
REQ-001 SHALL have parameter SRC_BASE, default 16'h6900, the CPU-space start address of the sprite shadow table.
REQ-002 SHALL have parameter XFER_LEN, default 10'h180, the number of bytes per transfer (1..1024).
REQ-003 SHALL have port clk, input, 1: system clock, 61.44 MHz.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port dma_en, input, 1: arms transfers; when low, vblk edges are ignored.
REQ-006 SHALL have port vblk, input, 1: vertical blank from dkong_video; synchronous to clk.
REQ-007 SHALL have port busrq_n, output, 1: Z80 bus request, active-low.
REQ-008 SHALL have port busak_n, input, 1: Z80 bus acknowledge, active-low.
REQ-009 SHALL have port src_addr, output, 16: work-RAM read address.
REQ-010 SHALL have port src_rd, output, 1: work-RAM read strobe; data is valid on src_data one clk later.
REQ-011 SHALL have port src_data, input, 8: work-RAM read data.
REQ-012 SHALL have port obj_addr, output, 10: object-RAM write address, to the dkong_video obj port.
REQ-013 SHALL have port obj_data, output, 8: object-RAM write data.
REQ-014 SHALL have port obj_wrn, output, 1: object-RAM write strobe, active-low.
REQ-015 SHALL have port obj_ena, output, 1: object-RAM select, to dkong_video obj_ena.
REQ-016 SHALL have port vram_busy, input, 1: the video block owns object RAM; no write may issue while it is high.
REQ-017 SHALL have port dma_busy, output, 1: high from leaving IDLE until returning to IDLE.
REQ-018 SHALL have port overrun, output, 1: one-clk pulse when a trigger arrives while dma_busy is high.

Function
REQ-019 SHALL detect a trigger as a vblk rising edge, registered vblk 0 -> 1, while dma_en is 1.
REQ-020 SHALL implement FSM states IDLE, REQ, READ, LATCH, WRITE, RELEASE.
REQ-021 IDLE: on trigger, SHALL clear idx to 0 and go to REQ, asserting busrq_n=0 in the same clk.
REQ-022 REQ: SHALL hold busrq_n=0 and go to READ on the first clk with busak_n=0.
REQ-023 READ: SHALL drive src_addr = SRC_BASE + idx (16-bit wrap) and src_rd=1 for exactly one clk, then go to LATCH.
REQ-024 LATCH: SHALL register src_data into the data hold register, then go to WRITE.
REQ-025 WRITE: while vram_busy=1, SHALL hold obj_wrn=1 and obj_ena=0 and stay in WRITE.
REQ-026 WRITE: on the first clk with vram_busy=0, SHALL drive obj_ena=0->1, obj_wrn=0, obj_addr=idx[9:0] and obj_data=held byte for exactly one clk.
REQ-027 After the write in WRITE: if idx == XFER_LEN-1, SHALL go to RELEASE; otherwise SHALL increment idx and go to READ.
REQ-028 Minimum cost SHALL be 3 clk per byte, so the default transfer takes 1152 clk plus bus handshake.
REQ-029 RELEASE: SHALL drive busrq_n=1 and return to IDLE on the first clk with busak_n=1.
REQ-030 Triggers outside IDLE SHALL be dropped and SHALL pulse overrun for one clk; no queuing.
REQ-031 dma_en falling mid-transfer SHALL NOT abort the transfer.
REQ-032 Outside the WRITE strobe clk, obj_wrn SHALL be 1, obj_ena SHALL be 0, and src_rd SHALL be 0.
REQ-033 Writes SHALL be strictly ascending from address 0; no address is skipped or repeated.

Reset
REQ-034 While rst_n is asserted (high), the FSM SHALL be IDLE and all registers SHALL be cleared.
REQ-035 Reset values: busrq_n=1, src_rd=0, src_addr=0, obj_wrn=1, obj_ena=0, obj_addr=0, obj_data=0, dma_busy=0, overrun=0, registered vblk=0.
REQ-036 Reset mid-transfer SHALL release the bus immediately (busrq_n=1); after reset the block SHALL wait for a fresh trigger.

Structure
REQ-037 The FSM state enum, DKONG_OBJ_DMA_LEN (10'h180) and OBJ_RAM_AW (10) SHALL live in the shared dkong_video_pkg.
REQ-038 The block SHALL be a single module with no sub-module; the edge detect and counter are inline.

Verification
REQ-039 Default params, busak_n tied to busrq_n with 2-clk delay, vram_busy=0, RAM[6900+i]=i^8'hA5; pulse vblk -> 384 writes, obj_addr 0..383, data i^A5, busrq_n released after the last write.
REQ-040 vram_busy high for 10 clk during byte 5's WRITE -> no strobe in those 10 clk; byte 5 is written once, with correct data, on the clk vram_busy falls.
REQ-041 busak_n held high for 50 clk after busrq_n falls -> src_rd stays 0 throughout; the transfer completes normally after ack.
REQ-042 Second vblk edge during a transfer -> overrun=1 for one clk; the write count stays 384.
REQ-043 dma_en=0 with a vblk edge -> busrq_n stays 1 and no writes occur.
REQ-044 rst_n asserted at byte 100 -> busrq_n=1 and obj_ena=0 the same cycle; the next trigger restarts at obj_addr 0.
